// File: rtl/clock_monitor_pkg.sv
// Shared types and helpers for the clock monitor and its edge detector.
package clock_monitor_pkg;

    localparam int SYNC_STAGES = 2;
    // Widest counter the difference helper supports; CNT_W must not exceed it.
    localparam int MAX_W = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } state_t;

    function automatic logic [MAX_W:0] abs_diff(input logic [MAX_W:0] a,
                                                 input logic [MAX_W:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/clock_monitor_sync_edge_det.sv
// Two-flop synchronizer with a history flop; emits one-cycle rise/fall pulses
// for any asynchronous level input.
module sync_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic sync_out,
    output logic rise,
    output logic fall
);
    import clock_monitor_pkg::*;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign rise     = sync_out & ~hist_q;
    assign fall     = ~sync_out & hist_q;

endmodule

// File: rtl/clock_monitor.sv
// Measures period and high time of an asynchronous clock in system-clock
// cycles, tracks lock between successive measurements and flags a stopped clock.
module clock_monitor #(
    parameter int CNT_W    = 16,
    parameter int TOL      = 1,
    parameter int LOCK_CNT = 4,
    parameter int TIMEOUT  = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             mon_clk,
    output logic [CNT_W-1:0] period_cnt,
    output logic [CNT_W-1:0] high_cnt,
    output logic             meas_valid,
    output logic             locked,
    output logic             stalled
);
    import clock_monitor_pkg::*;

    localparam int MATCH_W = $clog2(LOCK_CNT + 1);

    localparam logic [CNT_W-1:0]   CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]   TO_X      = CNT_W'(TIMEOUT);
    localparam logic [MAX_W:0]     TOL_X     = (MAX_W + 1)'(TOL);
    localparam logic [MATCH_W-1:0] LOCK_X    = MATCH_W'(LOCK_CNT);
    localparam logic [MATCH_W-1:0] MATCH_ONE = MATCH_W'(1);

    function automatic logic [MAX_W:0] ext(input logic [CNT_W-1:0] v);
        return {{(MAX_W + 1 - CNT_W){1'b0}}, v};
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? CNT_MAX : v + CNT_ONE;
    endfunction

    logic mon_sync, mon_rise, mon_fall;

    sync_edge_det u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (mon_clk),
        .sync_out (mon_sync),
        .rise     (mon_rise),
        .fall     (mon_fall)
    );

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   per_cnt_q, per_cnt_d;
    logic [CNT_W-1:0]   hi_cnt_q, hi_cnt_d;
    logic [CNT_W-1:0]   hi_lat_q, hi_lat_d;
    logic [CNT_W-1:0]   period_q, period_d;
    logic [CNT_W-1:0]   high_q, high_d;
    logic [CNT_W-1:0]   prev_per_q, prev_per_d;
    logic [CNT_W-1:0]   prev_hi_q, prev_hi_d;
    logic               have_prev_q, have_prev_d;
    logic [MATCH_W-1:0] match_q, match_d;
    logic               mv_q, mv_d;
    logic               locked_q, locked_d;
    logic               stalled_q, stalled_d;

    logic [MAX_W:0]     per_diff, hi_diff;
    logic               is_match;
    logic [MATCH_W-1:0] match_inc;

    // A saturated period means the counter overflowed, so it can never match.
    assign per_diff  = abs_diff(ext(per_cnt_q), ext(prev_per_q));
    assign hi_diff   = abs_diff(ext(hi_lat_q), ext(prev_hi_q));
    assign is_match  = have_prev_q && (per_diff <= TOL_X) && (hi_diff <= TOL_X)
                       && (per_cnt_q != CNT_MAX);
    assign match_inc = (match_q == LOCK_X) ? LOCK_X : match_q + MATCH_ONE;

    always_comb begin
        state_d     = state_q;
        per_cnt_d   = per_cnt_q;
        hi_cnt_d    = hi_cnt_q;
        hi_lat_d    = hi_lat_q;
        period_d    = period_q;
        high_d      = high_q;
        prev_per_d  = prev_per_q;
        prev_hi_d   = prev_hi_q;
        have_prev_d = have_prev_q;
        match_d     = match_q;
        mv_d        = 1'b0;
        locked_d    = locked_q;
        stalled_d   = stalled_q;

        if (!enable) begin
            state_d     = IDLE;
            per_cnt_d   = '0;
            hi_cnt_d    = '0;
            have_prev_d = 1'b0;
            match_d     = '0;
            locked_d    = 1'b0;
            stalled_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    per_cnt_d   = '0;
                    hi_cnt_d    = '0;
                    have_prev_d = 1'b0;
                    match_d     = '0;
                    locked_d    = 1'b0;
                    stalled_d   = 1'b0;
                    state_d     = ARM;
                end
                ARM: begin
                    if (mon_rise) begin
                        per_cnt_d   = CNT_ONE;
                        hi_cnt_d    = CNT_ONE;
                        have_prev_d = 1'b0;
                        stalled_d   = 1'b0;
                        state_d     = MEASURE;
                    end else if (per_cnt_q >= TO_X) begin
                        per_cnt_d = '0;
                        hi_cnt_d  = '0;
                        match_d   = '0;
                        locked_d  = 1'b0;
                        stalled_d = 1'b1;
                    end else begin
                        per_cnt_d = sat_inc(per_cnt_q);
                    end
                end
                MEASURE: begin
                    if (mon_rise) begin
                        period_d    = per_cnt_q;
                        high_d      = hi_lat_q;
                        mv_d        = 1'b1;
                        prev_per_d  = per_cnt_q;
                        prev_hi_d   = hi_lat_q;
                        have_prev_d = 1'b1;
                        if (is_match) begin
                            match_d  = match_inc;
                            locked_d = (match_inc == LOCK_X);
                        end else if (have_prev_q) begin
                            match_d  = '0;
                            locked_d = 1'b0;
                        end
                        per_cnt_d = CNT_ONE;
                        hi_cnt_d  = CNT_ONE;
                    end else if (per_cnt_q >= TO_X) begin
                        per_cnt_d = '0;
                        hi_cnt_d  = '0;
                        match_d   = '0;
                        locked_d  = 1'b0;
                        stalled_d = 1'b1;
                        state_d   = ARM;
                    end else begin
                        per_cnt_d = sat_inc(per_cnt_q);
                        // High time accumulates only while the synchronized level is high.
                        if (mon_fall) begin
                            hi_lat_d = hi_cnt_q;
                        end else if (mon_sync) begin
                            hi_cnt_d = sat_inc(hi_cnt_q);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            per_cnt_q   <= '0;
            hi_cnt_q    <= '0;
            hi_lat_q    <= '0;
            period_q    <= '0;
            high_q      <= '0;
            prev_per_q  <= '0;
            prev_hi_q   <= '0;
            have_prev_q <= 1'b0;
            match_q     <= '0;
            mv_q        <= 1'b0;
            locked_q    <= 1'b0;
            stalled_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            per_cnt_q   <= per_cnt_d;
            hi_cnt_q    <= hi_cnt_d;
            hi_lat_q    <= hi_lat_d;
            period_q    <= period_d;
            high_q      <= high_d;
            prev_per_q  <= prev_per_d;
            prev_hi_q   <= prev_hi_d;
            have_prev_q <= have_prev_d;
            match_q     <= match_d;
            mv_q        <= mv_d;
            locked_q    <= locked_d;
            stalled_q   <= stalled_d;
        end
    end

    assign period_cnt = period_q;
    assign high_cnt   = high_q;
    assign meas_valid = mv_q;
    assign locked     = locked_q;
    assign stalled    = stalled_q;

endmodule
